adder_bist: RTL and testbench

Self-test driver and checker for the parameterized ripple adder (`{cout,sum} = a+b+cin`). It generates a reproducible pseudo-random operand sequence, drives the adder's `a`/`b`/`cin` inputs, and samples `sum`/`cout`. Each sample is compared against an internal golden sum, and the block reports error count, first failing vector and pass/fail. It sits beside an adder instance as a synthesizable BIST, replacing the free-running `$random` stimulus in simulation-only benches.

---
 rtl/adder_bist_pkg.sv | 14 +
 rtl/adder_bist_if.sv | 32 +++
 rtl/adder_bist_lfsr32.sv | 33 +++
 rtl/adder_bist.sv | 123 ++++++++++++
 tb/tb_adder_bist.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder self-test block.
package adder_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;
  localparam int unsigned FAIL_IDX_W = 16;

endpackage

// File: rtl/adder_bist_if.sv
// Bundle between the self-test block and the adder / run controller.
interface adder_bist_if #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned CNT_W = 8
);
  import adder_bist_pkg::*;

  logic                  start;
  logic [SIZE-1:0]       op_a;
  logic [SIZE-1:0]       op_b;
  logic                  op_cin;
  logic [SIZE-1:0]       res_sum;
  logic                  res_cout;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [CNT_W-1:0]      err_count;
  logic [FAIL_IDX_W-1:0] fail_idx;

  // Controller / adder side
  modport master (
    output start, res_sum, res_cout,
    input  op_a, op_b, op_cin, busy, done, pass, err_count, fail_idx
  );

  // Self-test block side
  modport slave (
    input  start, res_sum, res_cout,
    output op_a, op_b, op_cin, busy, done, pass, err_count, fail_idx
  );

endinterface

// File: rtl/adder_bist_lfsr32.sv
// 32-bit Galois LFSR with seed load; a zero seed is replaced by 1.
module lfsr32
  import adder_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state
);

  logic [31:0] state_q, state_d;

  // Next value: load wins over step, otherwise hold
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed == 32'h0) ? 32'h1 : seed;
    end else if (step) begin
      state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? LFSR_MASK : 32'h0);
    end
  end

  // State register; reset to zero keeps operands at 0 until a run loads the seed
  always_ff @(posedge clk) begin
    if (rst) state_q <= 32'h0;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/adder_bist.sv
// Built-in self test for a SIZE-bit ripple adder: drives LFSR vectors, checks results.
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int unsigned SIZE        = 4,
  parameter int unsigned NUM_VECTORS = 16,
  parameter logic [31:0] SEED        = 32'h0000_0001,
  parameter int unsigned CNT_W       = 8
) (
  input logic         clk,
  input logic         rst,
  adder_bist_if.slave bus_if
);

  localparam int unsigned SW       = SIZE + 1;
  localparam int unsigned IDX_W    = FAIL_IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [IDX_W-1:0]   fail_q, fail_d;
  logic               seen_q, seen_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               lfsr_load_c, lfsr_step_c;
  logic [31:0]        lfsr;
  logic [SW-1:0]      expected_c, observed_c;
  logic               mismatch_c;
  logic               unused_lfsr_c;

  lfsr32 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load_c),
    .seed  (SEED),
    .step  (lfsr_step_c),
    .state (lfsr)
  );

  // Golden sum of the vector currently on the operands vs. the adder result
  always_comb begin
    expected_c = SW'(bus_if.op_a) + SW'(bus_if.op_b) + SW'(bus_if.op_cin);
    observed_c = {bus_if.res_cout, bus_if.res_sum};
    mismatch_c = (expected_c != observed_c);
  end

  // Run sequencing, index stepping, saturating error count and first-fail capture
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    err_d       = err_q;
    fail_d      = fail_q;
    seen_d      = seen_q;
    lfsr_load_c = 1'b0;
    lfsr_step_c = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus_if.start) begin
          state_d     = ST_DRIVE;
          lfsr_load_c = 1'b1;
          idx_d       = '0;
          err_d       = '0;
          fail_d      = '0;
          seen_d      = 1'b0;
        end
      end
      ST_DRIVE: state_d = ST_CHECK;
      ST_CHECK: begin
        if (mismatch_c) begin
          if (err_q != {CNT_W{1'b1}}) err_d = err_q + CNT_W'(1);
          if (!seen_q) begin
            seen_d = 1'b1;
            fail_d = idx_q;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          state_d     = ST_DRIVE;
          lfsr_step_c = 1'b1;
          idx_d       = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_DRIVE) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
  end

  // Registered state and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      seen_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      seen_q  <= seen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus_if.op_a      = lfsr[SIZE-1:0];
  assign bus_if.op_b      = lfsr[2*SIZE-1:SIZE];
  assign bus_if.op_cin    = lfsr[2*SIZE];
  assign bus_if.busy      = busy_q;
  assign bus_if.done      = done_q;
  assign bus_if.pass      = done_q & (err_q == '0);
  assign bus_if.err_count = err_q;
  assign bus_if.fail_idx  = fail_q;

  assign unused_lfsr_c = ^lfsr[31:2*SIZE+1];

endmodule

// File: tb/tb_adder_bist.sv
// Self-checking bench for adder_bist: behavioural adder with injectable faults.
module tb_adder_bist;

  localparam int NV = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [15:0] fault_mask;
  bit          fault_cout;
  logic [3:0]  tb_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder_bist_if #(.SIZE(4), .CNT_W(8)) bus0 ();
  adder_bist_if #(.SIZE(4), .CNT_W(3)) bus1 ();

  adder_bist #(.SIZE(4), .NUM_VECTORS(16), .SEED(32'h1), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .bus_if(bus0.slave));
  adder_bist #(.SIZE(4), .NUM_VECTORS(16), .SEED(32'h1), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .bus_if(bus1.slave));

  assign bus0.start = start;
  assign bus1.start = start;

  // Behavioural adder for instance 0, corrupted on selected vector indices
  always_comb begin
    int t;
    t = int'(bus0.op_a) + int'(bus0.op_b) + int'(bus0.op_cin);
    bus0.res_sum  = 4'(t % 16);
    bus0.res_cout = 1'(t / 16);
    if (fault_mask[tb_idx]) begin
      if (fault_cout) bus0.res_cout = ~bus0.res_cout;
      else            bus0.res_sum  = ~bus0.res_sum;
    end
  end

  // Same adder model for the narrow-counter instance
  always_comb begin
    int t;
    t = int'(bus1.op_a) + int'(bus1.op_b) + int'(bus1.op_cin);
    bus1.res_sum  = 4'(t % 16);
    bus1.res_cout = 1'(t / 16);
    if (fault_mask[tb_idx]) begin
      if (fault_cout) bus1.res_cout = ~bus1.res_cout;
      else            bus1.res_sum  = ~bus1.res_sum;
    end
  end

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (((s % 2) == 1) ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_op_a"},  32'(bus0.op_a),      0);
    check({tag, "_op_b"},  32'(bus0.op_b),      0);
    check({tag, "_cin"},   32'(bus0.op_cin),    0);
    check({tag, "_busy"},  32'(bus0.busy),      0);
    check({tag, "_done"},  32'(bus0.done),      0);
    check({tag, "_pass"},  32'(bus0.pass),      0);
    check({tag, "_err"},   32'(bus0.err_count), 0);
    check({tag, "_fidx"},  32'(bus0.fail_idx),  0);
    check({tag, "_err3"},  32'(bus1.err_count), 0);
  endtask

  // One full run from a start pulse; optional stray start and mid-run reset edges
  task automatic run(input logic [15:0] mask, input bit use_cout, input int late_start,
                     input int rst_edge, input int exp_err, input int exp_err3,
                     input int exp_fail);
    logic [31:0] s;
    s          = 32'h1;
    fault_mask = mask;
    fault_cout = use_cout;
    tb_idx     = 4'd0;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 0; e <= 2*NV; e++) begin
      if (rst_edge > 0 && e == rst_edge) begin
        check_reset_outputs("midrst");
        rst        = 1'b0;
        fault_mask = '0;
        return;
      end
      if (e < 2*NV && e % 2 == 0) begin
        tb_idx = 4'(e / 2);
        check("op_a",   32'(bus0.op_a),   s % 16);
        check("op_b",   32'(bus0.op_b),   (s / 16) % 16);
        check("op_cin", 32'(bus0.op_cin), (s / 256) % 2);
        check("busy",   32'(bus0.busy),   1);
        s = lfsr_next(s);
      end
      if (e == 2*NV - 1) check("done_early", 32'(bus0.done), 0);
      if (e == 2*NV) begin
        check("done",      32'(bus0.done),      1);
        check("busy_end",  32'(bus0.busy),      0);
        check("pass",      32'(bus0.pass),      32'(exp_err == 0));
        check("err_count", 32'(bus0.err_count), 32'(exp_err));
        check("fail_idx",  32'(bus0.fail_idx),  32'(exp_fail));
        check("err_sat",   32'(bus1.err_count), 32'(exp_err3));
        check("pass_sat",  32'(bus1.pass),      32'(exp_err == 0));
        check("fidx_sat",  32'(bus1.fail_idx),  32'(exp_fail));
      end else begin
        rst   = (rst_edge > 0 && e + 1 == rst_edge);
        start = (late_start > 0 && e + 1 == late_start);
        @(posedge clk); #1;
      end
    end
    start      = 1'b0;
    fault_mask = '0;
  endtask

  typedef struct {
    logic [15:0] mask;
    bit          use_cout;
    int          exp_err;
    int          exp_err3;
    int          exp_fail;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int gap, cnt, first;
    bit found;
    logic [15:0] m;
    bit uc;

    tbl[0] = '{16'h0000, 1'b0, 0,  0, 0};
    tbl[1] = '{16'hFFFF, 1'b0, 16, 7, 0};
    tbl[2] = '{16'h0020, 1'b1, 1,  1, 5};
    tbl[3] = '{16'h8000, 1'b1, 1,  1, 15};
    tbl[4] = '{16'h00F0, 1'b0, 4,  4, 4};

    rst = 1'b1; start = 1'b0; fault_mask = '0; fault_cout = 1'b0; tb_idx = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i])
      run(tbl[i].mask, tbl[i].use_cout, 0, 0, tbl[i].exp_err, tbl[i].exp_err3, tbl[i].exp_fail);

    // Stray start mid-run is ignored; completion still at edge 32
    run(16'h0000, 1'b0, 7, 0, 0, 0, 0);

    // done and pass hold while idle
    repeat (3) @(posedge clk);
    #1;
    check("done_held", 32'(bus0.done), 1);
    check("pass_held", 32'(bus0.pass), 1);

    // Random fault patterns against the counting model
    for (int r = 0; r < 6; r++) begin
      m  = 16'($urandom);
      uc = 1'($urandom % 2);
      cnt = 0; first = 0; found = 1'b0;
      for (int k = 0; k < NV; k++) begin
        if (m[k]) begin
          cnt++;
          if (!found) begin first = k; found = 1'b1; end
        end
      end
      gap = int'($urandom_range(0, 3));
      repeat (gap) begin @(posedge clk); #1; end
      run(m, uc, 0, 0, cnt, (cnt > 7) ? 7 : cnt, first);
    end

    // Reset in the middle of a run
    run(16'hFFFF, 1'b0, 0, 10, 0, 0, 0);

    // Reset and start together: reset wins
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", 32'(bus0.busy), 0);
    check("rst_start_opa",  32'(bus0.op_a), 0);

    // Fresh run after reset, then a second start after done
    run(16'h0000, 1'b0, 0, 0, 0, 0, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_op_a", 32'(bus0.op_a),   1);
    check("restart_op_b", 32'(bus0.op_b),   0);
    check("restart_cin",  32'(bus0.op_cin), 0);
    check("restart_busy", 32'(bus0.busy),   1);
    check("restart_done", 32'(bus0.done),   0);
    repeat (31) @(posedge clk);
    #1;
    check("restart_done31", 32'(bus0.done), 0);
    @(posedge clk); #1;
    check("restart_done32", 32'(bus0.done), 1);
    check("restart_pass",   32'(bus0.pass), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
